axis_accum_sink: RTL
====================

AXIS_ACCUM_SINK -- requirements
Module: axis_accum_sink

Interface
REQ-001 SHALL have parameter C_S_AXIS_TDATA_WIDTH, default 32, input data width (multiple of 8).
REQ-002 SHALL have parameter C_ACC_WIDTH, default 48, accumulator and result width (>= C_S_AXIS_TDATA_WIDTH).
REQ-003 SHALL have parameter C_TDEST_WIDTH, default 2, channel-select width; channel count = 2**C_TDEST_WIDTH.
REQ-004 SHALL have parameter C_BEAT_WIDTH, default 16, per-packet beat-counter width.
REQ-005 SHALL have parameter C_RES_DEPTH, default 4, result FIFO depth (power of two, >= 2).
REQ-006 SHALL have port S_AXIS_ACLK, input, 1, the single clock; all logic is rising-edge.
REQ-007 SHALL have port S_AXIS_ARESET, input, 1, reset, asynchronous and active-high.
REQ-008 SHALL have ports S_AXIS_TDATA, input, C_S_AXIS_TDATA_WIDTH; S_AXIS_TSTRB, input, C_S_AXIS_TDATA_WIDTH/8; S_AXIS_TDEST, input, C_TDEST_WIDTH; S_AXIS_TLAST, input, 1; S_AXIS_TVALID, input, 1; S_AXIS_TREADY, output, 1.
REQ-009 SHALL have ports M_RES_VALID, output, 1; M_RES_READY, input, 1; M_RES_SUM, output, C_ACC_WIDTH; M_RES_DEST, output, C_TDEST_WIDTH; M_RES_BEATS, output, C_BEAT_WIDTH.
REQ-010 SHALL have port ovf_sticky, output, 2**C_TDEST_WIDTH, per-channel overflow flag.

Function
REQ-011 SHALL accept an input beat only on the cycle when S_AXIS_TVALID and S_AXIS_TREADY are both high.
REQ-012 SHALL drive S_AXIS_TREADY = not result-FIFO-full, registered from FIFO state; a pop in cycle N raises TREADY no earlier than N+1.
REQ-013 SHALL zero every byte lane whose TSTRB bit is 0 and zero-extend the masked word to C_ACC_WIDTH before adding.
REQ-014 SHALL keep one accumulator, one beat counter and one state bit per channel; the channel is selected by S_AXIS_TDEST on the accepted beat.
REQ-015 SHALL run the per-channel FSM: IDLE -> OPEN on an accepted non-last beat; OPEN -> IDLE on an accepted TLAST beat; IDLE -> IDLE on an accepted single-beat packet (TLAST on its first beat).
REQ-016 SHALL add the masked beat into the selected accumulator and increment its beat counter; a beat arriving in IDLE starts from sum 0 and count 0.
REQ-017 SHALL saturate the beat counter at all-ones.
REQ-018 SHALL, on an accepted TLAST beat, push {final sum including that beat, TDEST, final beat count} into the result FIFO and clear that channel's accumulator and counter in the same edge.
REQ-019 SHALL present M_RES_VALID high one cycle after the TLAST handshake when the FIFO was empty (latency 1).
REQ-020 SHALL pop the FIFO head when M_RES_VALID and M_RES_READY are both high; M_RES_* SHALL hold stable while M_RES_VALID is high and M_RES_READY is low.
REQ-021 SHALL complete push and pop in the same cycle when the FIFO is non-empty and not full, leaving occupancy unchanged.
REQ-022 SHALL set ovf_sticky[ch] when an addition on channel ch carries out of C_ACC_WIDTH; it SHALL clear only on reset.
REQ-023 SHALL leave channels other than the addressed one unaffected by any beat, including interleaved packets on different TDEST values.

Reset
REQ-024 SHALL, while S_AXIS_ARESET is high, force S_AXIS_TREADY=0, M_RES_VALID=0, M_RES_SUM=0, M_RES_DEST=0, M_RES_BEATS=0, ovf_sticky=0, all channels IDLE, all accumulators and counters 0, and the FIFO empty.
REQ-025 SHALL discard any open packets and queued results on reset mid-operation; S_AXIS_TREADY SHALL rise on the first clock edge after reset deasserts.

Configuration
REQ-026 SHALL, with macro AXIS_ACCUM_SATURATE_EN defined, clamp each accumulator at all-ones on overflow (still setting ovf_sticky); without it, the sum SHALL wrap modulo 2**C_ACC_WIDTH.

Structure
REQ-027 SHALL place the channel-state enum (IDLE/OPEN) and the result-record typedef {sum, dest, beats} in package axis_accum_pkg.
REQ-028 SHALL implement the result queue as sub-module axis_accum_res_fifo (synchronous, registered full/empty flags, async active-high reset).

Verification
REQ-029 SHALL cover: 3-beat packet on TDEST=1 with data 1,2,3, TSTRB=4'hF -> one result SUM=6, DEST=1, BEATS=3, valid one cycle after TLAST.
REQ-030 SHALL cover: a single beat 32'hAABBCCDD with TSTRB=4'b0101 and TLAST -> SUM=32'h00BB00DD, BEATS=1.
REQ-031 SHALL cover: interleaved beats on TDEST 0 (1,1) and TDEST 2 (5,5,5) -> results SUM=2/BEATS=2 and SUM=15/BEATS=3, in TLAST order.
REQ-032 SHALL cover: M_RES_READY=0 with 5 one-beat packets, depth 4 -> TREADY low after the 4th result; the 5th beat stalls; one pop re-raises TREADY the next cycle.
REQ-033 SHALL cover: C_ACC_WIDTH=32, beats 32'hFFFFFFFF and 2 -> ovf_sticky[0]=1; SUM=1 without the macro, SUM=32'hFFFFFFFF with AXIS_ACCUM_SATURATE_EN.
REQ-034 SHALL cover: reset asserted mid-packet with 2 queued results -> M_RES_VALID=0 immediately; a following 1-beat packet with data 7 gives SUM=7.

Source files
------------

// File: rtl/axis_accum_pkg.sv
// axis_accum_pkg: channel-state enum and result-record type shared by the accumulating sink
package axis_accum_pkg;

    // The record is sized for the widest supported configuration; instances zero-extend into it
    localparam int MAX_ACC_W  = 64;
    localparam int MAX_DEST_W = 8;
    localparam int MAX_BEAT_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } ch_state_t;

    typedef struct packed {
        logic [MAX_ACC_W-1:0]  sum;
        logic [MAX_DEST_W-1:0] dest;
        logic [MAX_BEAT_W-1:0] beats;
    } res_rec_t;

endpackage

// File: rtl/axis_accum_res_fifo.sv
// axis_accum_res_fifo: synchronous result queue with registered full/empty flags
module axis_accum_res_fifo
    import axis_accum_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  res_rec_t din,
    input  logic     pop,
    output res_rec_t dout,
    output logic     empty,
    output logic     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    res_rec_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic do_push, do_pop;

    // Qualified push/pop and the occupancy they produce
    always_comb begin
        do_push    = push & ~full;
        do_pop     = pop & ~empty;
        count_next = count + CW'(do_push) - CW'(do_pop);
    end

    // Pointers, occupancy and flags are registered from the next occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count_next;
            empty  <= count_next == '0;
            full   <= count_next == CW'(DEPTH);
        end
    end

    // Storage needs no reset; the empty flag masks stale entries
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/axis_accum_sink.sv
// axis_accum_sink: per-TDEST packet accumulator; AXIS_ACCUM_SATURATE_EN clamps sums instead of wrapping
module axis_accum_sink
    import axis_accum_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_ACC_WIDTH          = 48,
    parameter int C_TDEST_WIDTH        = 2,
    parameter int C_BEAT_WIDTH         = 16,
    parameter int C_RES_DEPTH          = 4
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESET,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic [C_TDEST_WIDTH-1:0]          S_AXIS_TDEST,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    output logic                              M_RES_VALID,
    input  logic                              M_RES_READY,
    output logic [C_ACC_WIDTH-1:0]            M_RES_SUM,
    output logic [C_TDEST_WIDTH-1:0]          M_RES_DEST,
    output logic [C_BEAT_WIDTH-1:0]           M_RES_BEATS,
    output logic [2**C_TDEST_WIDTH-1:0]       ovf_sticky
);
    localparam int NCH = 2**C_TDEST_WIDTH;
    localparam int NB  = C_S_AXIS_TDATA_WIDTH / 8;

    ch_state_t                 state      [NCH];
    ch_state_t                 state_next [NCH];
    logic [C_ACC_WIDTH-1:0]    acc        [NCH];
    logic [C_BEAT_WIDTH-1:0]   beats      [NCH];
    logic                      alive, empty, full, fire, push, pop, carry;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] masked;
    logic [C_ACC_WIDTH-1:0]    base_sum, raw_sum, sum_new;
    logic [C_BEAT_WIDTH-1:0]   base_cnt, cnt_new;
    res_rec_t                  din, head;
    logic                      unused_head;

    // Ready only once out of reset, and only while the result queue has room
    assign S_AXIS_TREADY = alive & ~full;
    assign fire          = S_AXIS_TVALID & S_AXIS_TREADY;
    assign push          = fire & S_AXIS_TLAST;
    assign pop           = M_RES_READY & ~empty;
    assign M_RES_VALID   = ~empty;
    assign M_RES_SUM     = empty ? '0 : head.sum[C_ACC_WIDTH-1:0];
    assign M_RES_DEST    = empty ? '0 : head.dest[C_TDEST_WIDTH-1:0];
    assign M_RES_BEATS   = empty ? '0 : head.beats[C_BEAT_WIDTH-1:0];
    assign unused_head   = ^head;

    // Lane masking, addition into the addressed channel and its beat count
    always_comb begin
        masked = '0;
        for (int i = 0; i < NB; i++)
            masked[8*i +: 8] = S_AXIS_TSTRB[i] ? S_AXIS_TDATA[8*i +: 8] : 8'h00;
        base_sum = state[S_AXIS_TDEST] == ST_OPEN ? acc[S_AXIS_TDEST] : '0;
        base_cnt = state[S_AXIS_TDEST] == ST_OPEN ? beats[S_AXIS_TDEST] : '0;
        {carry, raw_sum} = {1'b0, base_sum} + {1'b0, C_ACC_WIDTH'(masked)};
`ifdef AXIS_ACCUM_SATURATE_EN
        sum_new = carry ? '1 : raw_sum;
`else
        sum_new = raw_sum;
`endif
        cnt_new = &base_cnt ? base_cnt : base_cnt + C_BEAT_WIDTH'(1);
        din = '{sum: MAX_ACC_W'(sum_new), dest: MAX_DEST_W'(S_AXIS_TDEST), beats: MAX_BEAT_W'(cnt_new)};
    end

    // Next channel state: only the addressed channel moves on an accepted beat
    always_comb begin
        for (int c = 0; c < NCH; c++) state_next[c] = state[c];
        if (fire) state_next[S_AXIS_TDEST] = S_AXIS_TLAST ? ST_IDLE : ST_OPEN;
    end

    // Channel state register
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            for (int c = 0; c < NCH; c++) state[c] <= ST_IDLE;
        end else begin
            for (int c = 0; c < NCH; c++) state[c] <= state_next[c];
        end
    end

    // Accumulators and counters; a closing beat clears its channel as the result is queued
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            for (int c = 0; c < NCH; c++) begin
                acc[c]   <= '0;
                beats[c] <= '0;
            end
            ovf_sticky <= '0;
        end else if (fire) begin
            acc[S_AXIS_TDEST]   <= S_AXIS_TLAST ? '0 : sum_new;
            beats[S_AXIS_TDEST] <= S_AXIS_TLAST ? '0 : cnt_new;
            if (carry) ovf_sticky[S_AXIS_TDEST] <= 1'b1;
        end
    end

    // Holds TREADY low until the first edge after reset releases
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) alive <= 1'b0;
        else alive <= 1'b1;
    end

    axis_accum_res_fifo #(
        .DEPTH (C_RES_DEPTH)
    ) u_fifo (
        .clk   (S_AXIS_ACLK),
        .rst   (S_AXIS_ARESET),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

endmodule
